pixel_readout_rx: RTL and testbench

//  Receive end of the pixel-array readout interface: follows PIXEL_STATE phase strobes, samples the
//  two 8-bit column buses per read phase, assembles row0+row1 into one 32-bit word per frame,

---
 rtl/pixel_rx_pkg.sv | 24 ++
 rtl/pixel_rx_if.sv | 12 +
 rtl/pixel_rx_fifo.sv | 55 +++++
 rtl/pixel_readout_rx.sv | 118 +++++++++++
 tb/tb_pixel_readout_rx.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_rx_pkg.sv
// rtl/pixel_rx_pkg.sv - shared types, widths and Gray decode for the pixel readout receiver
package pixel_rx_pkg;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    WAIT_R0,
    SETTLE_R0,
    WAIT_R1,
    SETTLE_R1,
    PUSH
  } rx_state_t;

  function automatic logic [PIX_W-1:0] gray2bin(input logic [PIX_W-1:0] g);
    logic [PIX_W-1:0] b;
    b[PIX_W-1] = g[PIX_W-1];
    for (int i = PIX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/pixel_rx_if.sv
// rtl/pixel_rx_if.sv - valid/ready word stream from the receiver to the downstream sink
interface pixel_rx_if;
  import pixel_rx_pkg::*;

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/pixel_rx_fifo.sv
// rtl/pixel_rx_fifo.sv - synchronous word FIFO; a pop frees its slot for a same-cycle push when full
module pixel_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_readout_rx.sv
// rtl/pixel_readout_rx.sv - follows read strobes, captures two rows per frame, queues 32-bit words
// Define PIXEL_RX_GRAY_EN to Gray-decode every column sample on its way into the row registers.
module pixel_readout_rx
  import pixel_rx_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             erase,
  input  logic             read0,
  input  logic             read1,
  input  logic [PIX_W-1:0] dataIn1,
  input  logic [PIX_W-1:0] dataIn2,
  pixel_rx_if.master       out_if,
  output logic             overflow,
  output logic             proto_err,
  output logic [15:0]      frame_cnt
);

  rx_state_t          state, next_state;
  logic               read0_q, read1_q;
  logic               rise0, rise1, both;
  logic [3:0]         cnt;
  logic [2*PIX_W-1:0] row0, row1, sample;
  logic               hold, load_cnt, dec_cnt, take_r0, take_r1, do_push;
  logic               pop, push_ok, fifo_full, fifo_empty;

  assign rise0 = read0 && !read0_q;
  assign rise1 = read1 && !read1_q;
  assign both  = read0 && read1;

`ifdef PIXEL_RX_GRAY_EN
  assign sample = {gray2bin(dataIn2), gray2bin(dataIn1)};
`else
  assign sample = {dataIn2, dataIn1};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_R0;
    end else begin
      state <= next_state;
    end
  end

  // Erase and the illegal both-strobes case override every state except PUSH.
  always_comb begin
    next_state = state;
    case (state)
      WAIT_R0:   if (rise0) next_state = SETTLE_R0;
      SETTLE_R0: if (cnt == '0) next_state = WAIT_R1;
      WAIT_R1: begin
        if (rise0)      next_state = SETTLE_R0;
        else if (rise1) next_state = SETTLE_R1;
      end
      SETTLE_R1: if (cnt == '0) next_state = PUSH;
      PUSH:      next_state = WAIT_R0;
      default:   next_state = WAIT_R0;
    endcase
    if (state != PUSH) begin
      if (erase)     next_state = WAIT_R0;
      else if (both) next_state = state;
    end
  end

  always_comb begin
    hold     = (state != PUSH) && !erase && both;
    load_cnt = ((next_state == SETTLE_R0) || (next_state == SETTLE_R1)) && (next_state != state);
    dec_cnt  = ((state == SETTLE_R0) || (state == SETTLE_R1)) && (next_state == state) && !hold;
    take_r0  = (state == SETTLE_R0) && (next_state == WAIT_R1);
    take_r1  = (state == SETTLE_R1) && (next_state == PUSH);
    do_push  = (state == PUSH);
  end

  assign pop              = out_if.out_valid && out_if.out_ready;
  assign push_ok          = do_push && (!fifo_full || pop);
  assign out_if.out_valid = !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read0_q   <= 1'b0;
      read1_q   <= 1'b0;
      cnt       <= '0;
      row0      <= '0;
      row1      <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      read0_q <= read0;
      read1_q <= read1;
      if (load_cnt)     cnt <= 4'(SETTLE_CYCLES);
      else if (dec_cnt) cnt <= cnt - 4'd1;
      if (take_r0) row0 <= sample;
      if (take_r1) row1 <= sample;
      if (both)    proto_err <= 1'b1;
      if (do_push && !push_ok) overflow <= 1'b1;
      if (push_ok) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  pixel_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .wdata ({row1, row0}),
    .pop   (pop),
    .rdata (out_if.out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_pixel_readout_rx.sv
// tb/tb_pixel_readout_rx.sv - self-checking bench for pixel_readout_rx
module tb_pixel_readout_rx;

  localparam int SETTLE = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        erase = 1'b0;
  logic        read0 = 1'b0;
  logic        read1 = 1'b0;
  logic [7:0]  d1 = 8'h00;
  logic [7:0]  d2 = 8'h00;
  logic        overflow, proto_err;
  logic [15:0] frame_cnt;

  pixel_rx_if bus ();

  pixel_readout_rx #(.SETTLE_CYCLES(SETTLE), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .erase     (erase),
    .read0     (read0),
    .read1     (read1),
    .dataIn1   (d1),
    .dataIn2   (d2),
    .out_if    (bus),
    .overflow  (overflow),
    .proto_err (proto_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  int          exp_fc = 0;
  logic        exp_ovf = 1'b0;
  logic        exp_proto = 1'b0;
  logic [31:0] last_seen = '0;
  int          n_seen = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  typedef struct {
    logic [7:0]  r0c1, r0c2, r1c1, r1c2;
    int          w0, w1;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dec(input logic [7:0] v);
`ifdef PIXEL_RX_GRAY_EN
    logic [7:0] b;
    b = 8'h00;
    for (int s = 0; s < 8; s++) b = b ^ (v >> s);
    return b;
`else
    return v;
`endif
  endfunction

  // Reference: a finished frame lands in the FIFO only if a slot is free, else it is dropped.
  task automatic model_frame(input logic [7:0] a, b, c, d);
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back({dec(d), dec(c), dec(b), dec(a)});
      exp_fc = (exp_fc + 1) % 65536;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) check("hold_stable", bus.out_data, prev_data);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%0h expected none", bus.out_data);
        end else begin
          check("word", bus.out_data, exp_q.pop_front());
        end
        last_seen = bus.out_data;
        n_seen++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe0(input logic [7:0] a, b, input int w);
    d1 = a; d2 = b; read0 = 1'b1;
    tick(w);
    read0 = 1'b0;
    tick(SETTLE + 3);
  endtask

  task automatic send_frame(input logic [7:0] a, b, c, d, input int w0, w1);
    strobe0(a, b, w0);
    d1 = c; d2 = d; read1 = 1'b1;
    model_frame(a, b, c, d);
    tick(w1);
    read1 = 1'b0;
    tick(SETTLE + 6);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_frame_cnt"}, frame_cnt, exp_fc[15:0]);
    check({tag, "_overflow"}, overflow, exp_ovf);
    check({tag, "_proto_err"}, proto_err, exp_proto);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen0, guard;
    logic [7:0] ra, rb, rc, rd;
    bus.out_ready = 1'b1;

    tbl[0] = '{8'h12, 8'h34, 8'h78, 8'h56, 1, 1, 32'h56783412};
    tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 32'h00000000};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 2, 3, 32'hFFFFFFFF};
    tbl[3] = '{8'hA5, 8'h5A, 8'h0F, 8'hF0, 3, 1, 32'hF00F5AA5};

    tick(2);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 32'h0);
    check_status("rst");
    reset = 1'b1;
    tick(2);

`ifndef PIXEL_RX_GRAY_EN
    for (int i = 0; i < 4; i++) begin
      send_frame(tbl[i].r0c1, tbl[i].r0c2, tbl[i].r1c1, tbl[i].r1c2, tbl[i].w0, tbl[i].w1);
      check($sformatf("tbl%0d_word", i), last_seen, tbl[i].exp);
      check_status($sformatf("tbl%0d", i));
    end
`else
    send_frame(8'hC0, 8'h80, 8'h01, 8'h03, 1, 1);
    check("gray_word", last_seen, 32'h0201FF80);
    check_status("gray");
`endif

    // Back-pressure: five frames into a four-deep FIFO, then drain with random ready.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1, 1);
    end
    check("full_out_valid", bus.out_valid, 1'b1);
    check("full_overflow_set", overflow, 1'b1);
    check_status("full");
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      tick(1);
      guard++;
    end
    bus.out_ready = 1'b1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d words left, required 0", exp_q.size());
    end
    tick(2);
    check("drained_out_valid", bus.out_valid, 1'b0);

    // Erase in WAIT_R1 and in SETTLE_R0, a lone read1 in WAIT_R0, then one clean frame.
    seen0 = n_seen;
    strobe0(8'h11, 8'h22, 1);
    erase = 1'b1; tick(1); erase = 1'b0; tick(2);
    d1 = 8'h33; read1 = 1'b1; tick(1); read1 = 1'b0; tick(SETTLE + 4);
    d1 = 8'h44; read0 = 1'b1; tick(1); read0 = 1'b0; tick(1);
    erase = 1'b1; tick(1); erase = 1'b0; tick(SETTLE + 3);
    d1 = 8'h55; read1 = 1'b1; tick(1); read1 = 1'b0; tick(SETTLE + 4);
    send_frame(8'hBB, 8'hAA, 8'hDD, 8'hCC, 1, 1);
    check("erase_words", n_seen - seen0, 1);
`ifndef PIXEL_RX_GRAY_EN
    check("erase_word", last_seen, 32'hCCDDAABB);
`endif
    check_status("erase");

    // Both strobes in one cycle.
    seen0 = n_seen;
    read0 = 1'b1; read1 = 1'b1; tick(1);
    read0 = 1'b0; read1 = 1'b0; exp_proto = 1'b1; tick(SETTLE + 6);
    check("proto_no_word", n_seen - seen0, 0);
    check_status("proto");
    send_frame(8'h5C, 8'hC5, 8'h3E, 8'hE3, 1, 1);
    check("proto_then_frame", n_seen - seen0, 1);

    // Asynchronous reset while SETTLE_R1 is counting.
    strobe0(8'h01, 8'h02, 1);
    d1 = 8'h03; d2 = 8'h04; read1 = 1'b1; tick(1); read1 = 1'b0;
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    exp_fc = 0; exp_ovf = 1'b0; exp_proto = 1'b0;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_data", bus.out_data, 32'h0);
    check_status("arst");
    tick(2);
    reset = 1'b1;
    tick(2);
    send_frame(8'h9A, 8'hBC, 8'hDE, 8'hF0, 2, 2);
    check_status("after_arst");

    // Random frames, pulse widths, gaps and row-0 restarts.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        strobe0(8'($urandom), 8'($urandom), $urandom_range(1, 3));
      end
      send_frame(ra, rb, rc, rd, $urandom_range(1, 3), $urandom_range(1, 3));
      tick($urandom_range(0, 3));
    end
    tick(10);
    check_status("random");
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
